// File: rtl/uart_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_receiver: oversampling UART RX (start, DATA_WIDTH LSB-first, opt.    |
// | parity, stop). Define UART_RX_MAJORITY_EN for 3-tap mid-bit voting.       |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_receiver #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  parity_type,
    input  logic                  parity_enable,
    input  logic                  serial_data_in,
    output logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int unsigned c_CNT_W = $clog2(PRESCALE);
    localparam int unsigned c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0]              r_sync;
    logic                    w_rx;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_par_type;
    logic                    r_par_en;
    logic                    r_par_err;
    logic                    r_dv;
    logic                    r_pe;
    logic                    r_se;
    logic                    w_s;
    logic                    w_sample;
    logic                    w_cnt_last;
    logic                    w_idx_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], serial_data_in};
        end
    end

    assign w_rx = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
    // Votes from the two cycles before the decision point; the third tap is live rx.
    localparam logic [c_CNT_W-1:0] c_CNT_SAMPLE = c_CNT_W'(PRESCALE / 2 + 1);
    logic r_vote_early;
    logic r_vote_mid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vote_early <= 1'b1;
            r_vote_mid   <= 1'b1;
        end else begin
            if (r_cnt == c_CNT_W'(PRESCALE / 2 - 1)) r_vote_early <= w_rx;
            if (r_cnt == c_CNT_W'(PRESCALE / 2))     r_vote_mid   <= w_rx;
        end
    end

    assign w_s = (r_vote_early & r_vote_mid) | (r_vote_early & w_rx) | (r_vote_mid & w_rx);
`else
    localparam logic [c_CNT_W-1:0] c_CNT_SAMPLE = c_CNT_W'(PRESCALE / 2);
    assign w_s = w_rx;
`endif

    assign w_sample   = (r_cnt == c_CNT_SAMPLE);
    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_idx_last = (r_bit_idx == c_IDX_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_rx) w_state_next = S_START;
            S_START: begin
                if (w_sample && w_s)  w_state_next = S_IDLE;
                else if (w_cnt_last)  w_state_next = S_DATA;
            end
            S_DATA:   if (w_cnt_last && w_idx_last) w_state_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_cnt_last) w_state_next = S_STOP;
            // Leave STOP at mid-bit so a back-to-back start edge is not missed.
            S_STOP:   if (w_sample) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_par_type <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_err  <= 1'b0;
            r_dv       <= 1'b0;
            r_pe       <= 1'b0;
            r_se       <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            r_pe <= 1'b0;
            r_se <= 1'b0;

            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        r_par_type <= parity_type;
                        r_par_en   <= parity_enable;
                        r_par_err  <= 1'b0;
                    end
                end
                S_START: begin
                    r_bit_idx <= '0;
                end
                S_DATA: begin
                    if (w_sample) r_shift[r_bit_idx] <= w_s;
                    if (w_cnt_last && !w_idx_last) r_bit_idx <= r_bit_idx + 1'b1;
                end
                S_PARITY: begin
                    if (w_sample) r_par_err <= w_s ^ (^r_shift) ^ r_par_type;
                end
                S_STOP: begin
                    if (w_sample) begin
                        r_data <= r_shift;
                        r_dv   <= ~r_par_err & w_s;
                        r_pe   <= r_par_err;
                        r_se   <= ~w_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign parallel_data = r_data;
    assign data_valid    = r_dv;
    assign parity_error  = r_pe;
    assign stop_error    = r_se;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire
